// File: rtl/flobuffer_arb.sv
// flobuffer_arb: shares one flobuffer write port between num_req requesters.
// Direct (bypass) writes outrank FIFO writes. Within a class the winner is
// picked round-robin from ptr. The accepted word and its strobe are registered
// and appear one cycle after the transfer.
module flobuffer_arb #(
    parameter int num_req = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [16*num_req-1:0]  req_data_i,
    input  logic [7*num_req-1:0]   req_delay_i,
    input  logic [num_req-1:0]     req_valid_i,
    input  logic [num_req-1:0]     req_direct_i,
    output logic [num_req-1:0]     req_ready_o,
    output logic [15:0]            buf_data_o,
    output logic [6:0]             buf_delay_o,
    output logic                   buf_valid_o,
    output logic                   buf_direct_o,
    input  logic                   buf_full_i,
    input  logic                   buf_err_i,
    output logic [2:0]             grant_o,
    output logic                   err_o,
    output logic [15:0]            wr_cnt_o
);

    // Registered state.
    logic [2:0]  ptr_q,    ptr_d;
    logic        valid_q;
    logic        direct_q;
    logic [15:0] data_q;
    logic [6:0]  delay_q;
    logic [2:0]  grant_q;
    logic        err_q;
    logic [15:0] wr_cnt_q;

    // Arbitration results for the current cycle.
    logic [7:0]  dir_cand;
    logic [7:0]  fifo_cand;
    logic [7:0]  cand;
    logic [7:0]  onehot;
    logic        fifo_ok;
    logic        any_direct;
    logic        sel_found;
    logic [2:0]  sel_idx;
    logic [3:0]  sum;
    logic [15:0] sel_data;
    logic [6:0]  sel_delay;

    // Pick the winning requester: direct class first, then FIFO class, each
    // searched upward from ptr with wrap-around.
    always_comb begin
        // NOTE: every signal gets a default before any conditional assignment,
        // so no path leaves a value unassigned and no latch is inferred.
        dir_cand   = 8'(req_valid_i & req_direct_i);
        fifo_cand  = 8'(req_valid_i & ~req_direct_i);
        any_direct = |dir_cand;
        // full_o lags the write strobe by a cycle, so a FIFO word is never
        // accepted while the previous FIFO strobe is still on the wire.
        fifo_ok    = ~buf_full_i & ~valid_q;
        cand       = any_direct ? dir_cand : (fifo_ok ? fifo_cand : 8'h00);
        if (rst) begin
            cand = 8'h00;
        end

        sel_found = 1'b0;
        sel_idx   = 3'd0;
        sum       = 4'd0;
        for (int i = 0; i < num_req; i++) begin
            sum = {1'b0, ptr_q} + 4'(i);
            if (sum >= 4'(num_req)) begin
                sum = sum - 4'(num_req);
            end
            if (!sel_found && cand[sum[2:0]]) begin
                sel_found = 1'b1;
                sel_idx   = sum[2:0];
            end
        end

        onehot      = sel_found ? (8'h01 << sel_idx) : 8'h00;
        req_ready_o = onehot[num_req-1:0];

        sel_data  = 16'h0000;
        sel_delay = 7'h00;
        for (int k = 0; k < num_req; k++) begin
            if (sel_idx == 3'(k)) begin
                sel_data  = req_data_i[16*k +: 16];
                sel_delay = req_delay_i[7*k +: 7];
            end
        end

        ptr_d = ptr_q;
        if (sel_found) begin
            ptr_d = (sel_idx == 3'(num_req - 1)) ? 3'd0 : sel_idx + 3'd1;
        end
    end

    // Register the accepted word, its strobe, the pointer and the counters.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            ptr_q    <= 3'd0;
            valid_q  <= 1'b0;
            direct_q <= 1'b0;
            data_q   <= 16'h0000;
            delay_q  <= 7'h00;
            grant_q  <= 3'd0;
            err_q    <= 1'b0;
            wr_cnt_q <= 16'h0000;
        end else begin
            ptr_q    <= ptr_d;
            valid_q  <= sel_found & ~any_direct;
            direct_q <= sel_found & any_direct;
            if (sel_found) begin
                data_q  <= sel_data;
                delay_q <= sel_delay;
                grant_q <= sel_idx;
            end
            // Counted at the transfer edge so the count already includes the
            // word whose strobe is currently visible.
            wr_cnt_q <= wr_cnt_q + 16'(sel_found & ~any_direct);
            err_q    <= err_q | buf_err_i;
        end
    end

    // Outputs read as zero while reset is held; this also drops a strobe whose
    // transfer happened the cycle before reset.
    always_comb begin
        buf_valid_o  = valid_q  & ~rst;
        buf_direct_o = direct_q & ~rst;
        buf_data_o   = rst ? 16'h0000 : data_q;
        buf_delay_o  = rst ? 7'h00    : delay_q;
        grant_o      = rst ? 3'd0     : grant_q;
        err_o        = err_q & ~rst;
        wr_cnt_o     = rst ? 16'h0000 : wr_cnt_q;
    end

endmodule

// File: tb/tb_flobuffer_arb.sv
// Directed testbench for flobuffer_arb (num_req = 4).
// Inputs change 1 ns after a rising edge; outputs are checked 1-2 ns later.
module tb_flobuffer_arb;

    localparam int N = 4;

    logic           clk;
    logic           rst;
    logic [16*N-1:0] req_data_i;
    logic [7*N-1:0]  req_delay_i;
    logic [N-1:0]    req_valid_i;
    logic [N-1:0]    req_direct_i;
    logic [N-1:0]    req_ready_o;
    logic [15:0]     buf_data_o;
    logic [6:0]      buf_delay_o;
    logic            buf_valid_o;
    logic            buf_direct_o;
    logic            buf_full_i;
    logic            buf_err_i;
    logic [2:0]      grant_o;
    logic            err_o;
    logic [15:0]     wr_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    flobuffer_arb #(.num_req(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_data_i   (req_data_i),
        .req_delay_i  (req_delay_i),
        .req_valid_i  (req_valid_i),
        .req_direct_i (req_direct_i),
        .req_ready_o  (req_ready_o),
        .buf_data_o   (buf_data_o),
        .buf_delay_o  (buf_delay_o),
        .buf_valid_o  (buf_valid_o),
        .buf_direct_o (buf_direct_o),
        .buf_full_i   (buf_full_i),
        .buf_err_i    (buf_err_i),
        .grant_o      (grant_o),
        .err_o        (err_o),
        .wr_cnt_o     (wr_cnt_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation got %0t ns, limit 200000 ns", $time);
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        req_valid_i  = 4'hF;
        req_direct_i = 4'h0;
        cyc();
        cyc();
        #1;
        if (req_ready_o !== 4'h0) begin
            $display("FAIL reset_ready: got %b want 0000", req_ready_o); n_err++;
        end
        n_vec++;
        if ({buf_valid_o, buf_direct_o, err_o} !== 3'b000) begin
            $display("FAIL reset_strobes: got %b want 000", {buf_valid_o, buf_direct_o, err_o}); n_err++;
        end
        n_vec++;
        if ({buf_data_o, buf_delay_o, grant_o, wr_cnt_o} !== 42'h0) begin
            $display("FAIL reset_regs: got %h want 0", {buf_data_o, buf_delay_o, grant_o, wr_cnt_o}); n_err++;
        end
        n_vec++;
        req_valid_i = 4'h0;
        rst         = 1'b0;
    endtask

    task automatic test_single();
        req_data_i[16*2 +: 16] = 16'h0011;
        req_delay_i[7*2 +: 7]  = 7'd3;
        req_valid_i            = 4'b0100;
        #1;
        if (req_ready_o !== 4'b0100) begin
            $display("FAIL single_ready: got %b want 0100", req_ready_o); n_err++;
        end
        n_vec++;
        cyc();
        req_valid_i = 4'h0;
        if ({buf_valid_o, buf_direct_o} !== 2'b10) begin
            $display("FAIL single_strobe: got %b want 10", {buf_valid_o, buf_direct_o}); n_err++;
        end
        n_vec++;
        if (buf_data_o !== 16'h0011 || buf_delay_o !== 7'd3 || grant_o !== 3'd2) begin
            $display("FAIL single_word: got %h/%0d/%0d want 0011/3/2", buf_data_o, buf_delay_o, grant_o); n_err++;
        end
        n_vec++;
        if (wr_cnt_o !== 16'd1) begin
            $display("FAIL single_cnt: got %0d want 1", wr_cnt_o); n_err++;
        end
        n_vec++;
        cyc();
        if (buf_valid_o !== 1'b0 || buf_data_o !== 16'h0011) begin
            $display("FAIL single_hold: got %b/%h want 0/0011", buf_valid_o, buf_data_o); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_round_robin();
        logic [2:0]  k;
        logic [15:0] exp_data;
        do_reset();
        for (int r = 0; r < N; r++) begin
            req_data_i[16*r +: 16] = 16'h1000 + 16'(r);
            req_delay_i[7*r +: 7]  = 7'(10 + r);
        end
        req_valid_i  = 4'hF;
        req_direct_i = 4'h0;
        for (int j = 0; j < 5; j++) begin
            k        = 3'(j % N);
            exp_data = 16'h1000 + 16'(k);
            #1;
            if (req_ready_o !== (4'b0001 << k)) begin
                $display("FAIL rr_ready%0d: got %b want %b", j, req_ready_o, 4'b0001 << k); n_err++;
            end
            n_vec++;
            cyc();
            if (buf_valid_o !== 1'b1 || grant_o !== k || buf_data_o !== exp_data) begin
                $display("FAIL rr_out%0d: got %b/%0d/%h want 1/%0d/%h", j, buf_valid_o, grant_o, buf_data_o, k, exp_data); n_err++;
            end
            n_vec++;
            #1;
            if (req_ready_o !== 4'h0) begin
                $display("FAIL rr_block%0d: got %b want 0000", j, req_ready_o); n_err++;
            end
            n_vec++;
            cyc();
            if (j == 4) req_valid_i = 4'h0;
            if (buf_valid_o !== 1'b0) begin
                $display("FAIL rr_gap%0d: got %b want 0", j, buf_valid_o); n_err++;
            end
            n_vec++;
        end
        if (wr_cnt_o !== 16'd5) begin
            $display("FAIL rr_cnt: got %0d want 5", wr_cnt_o); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_direct_priority();
        do_reset();
        buf_full_i             = 1'b1;
        req_data_i[16*3 +: 16] = 16'hD003;
        req_data_i[16*1 +: 16] = 16'hF001;
        req_valid_i            = 4'b1010;
        req_direct_i           = 4'b1000;
        #1;
        if (req_ready_o !== 4'b1000) begin
            $display("FAIL dir_ready: got %b want 1000", req_ready_o); n_err++;
        end
        n_vec++;
        cyc();
        req_valid_i  = 4'b0010;
        req_direct_i = 4'b0000;
        if ({buf_valid_o, buf_direct_o} !== 2'b01 || grant_o !== 3'd3 || buf_data_o !== 16'hD003) begin
            $display("FAIL dir_out: got %b/%0d/%h want 01/3/d003", {buf_valid_o, buf_direct_o}, grant_o, buf_data_o); n_err++;
        end
        n_vec++;
        #1;
        if (req_ready_o !== 4'h0) begin
            $display("FAIL dir_full_block: got %b want 0000", req_ready_o); n_err++;
        end
        n_vec++;
        cyc();
        if (buf_direct_o !== 1'b0 || req_ready_o !== 4'h0) begin
            $display("FAIL dir_idle: got %b/%b want 0/0000", buf_direct_o, req_ready_o); n_err++;
        end
        n_vec++;
        buf_full_i = 1'b0;
        #1;
        if (req_ready_o !== 4'b0010) begin
            $display("FAIL dir_fifo_ready: got %b want 0010", req_ready_o); n_err++;
        end
        n_vec++;
        cyc();
        req_valid_i = 4'h0;
        if (buf_valid_o !== 1'b1 || grant_o !== 3'd1 || buf_data_o !== 16'hF001 || wr_cnt_o !== 16'd1) begin
            $display("FAIL dir_fifo_out: got %b/%0d/%h/%0d want 1/1/f001/1", buf_valid_o, grant_o, buf_data_o, wr_cnt_o); n_err++;
        end
        n_vec++;
        cyc();
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_valid_i  = 4'b0011;
        req_direct_i = 4'b0011;
        #1;
        if (req_ready_o !== 4'b0001) begin
            $display("FAIL b2b_ready0: got %b want 0001", req_ready_o); n_err++;
        end
        n_vec++;
        cyc();
        req_valid_i = 4'b0010;
        #1;
        if (buf_direct_o !== 1'b1 || grant_o !== 3'd0 || req_ready_o !== 4'b0010) begin
            $display("FAIL b2b_first: got %b/%0d/%b want 1/0/0010", buf_direct_o, grant_o, req_ready_o); n_err++;
        end
        n_vec++;
        cyc();
        req_valid_i  = 4'h0;
        req_direct_i = 4'h0;
        if (buf_direct_o !== 1'b1 || grant_o !== 3'd1 || wr_cnt_o !== 16'd0) begin
            $display("FAIL b2b_second: got %b/%0d/%0d want 1/1/0", buf_direct_o, grant_o, wr_cnt_o); n_err++;
        end
        n_vec++;
        cyc();
    endtask

    task automatic test_err();
        buf_err_i = 1'b1;
        #1;
        if (err_o !== 1'b0) begin
            $display("FAIL err_early: got %b want 0", err_o); n_err++;
        end
        n_vec++;
        cyc();
        buf_err_i = 1'b0;
        if (err_o !== 1'b1) begin
            $display("FAIL err_set: got %b want 1", err_o); n_err++;
        end
        n_vec++;
        cyc();
        cyc();
        if (err_o !== 1'b1) begin
            $display("FAIL err_sticky: got %b want 1", err_o); n_err++;
        end
        n_vec++;
        do_reset();
        if (err_o !== 1'b0 || wr_cnt_o !== 16'd0) begin
            $display("FAIL err_clear: got %b/%0d want 0/0", err_o, wr_cnt_o); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_wrap();
        do_reset();
        // Stand-in for 65534 earlier writes.
        dut.wr_cnt_q = 16'hFFFE;
        req_valid_i  = 4'b0001;
        cyc();
        req_valid_i = 4'h0;
        if (wr_cnt_o !== 16'hFFFF) begin
            $display("FAIL wrap_ffff: got %h want ffff", wr_cnt_o); n_err++;
        end
        n_vec++;
        cyc();
        req_valid_i = 4'b0010;
        cyc();
        req_valid_i = 4'h0;
        if (wr_cnt_o !== 16'h0000 || buf_valid_o !== 1'b1) begin
            $display("FAIL wrap_zero: got %h/%b want 0000/1", wr_cnt_o, buf_valid_o); n_err++;
        end
        n_vec++;
        cyc();
    endtask

    task automatic test_reset_after_transfer();
        do_reset();
        // Move ptr to 2 with a transfer from requester 1.
        req_valid_i = 4'b0010;
        cyc();
        req_valid_i = 4'h0;
        cyc();
        req_data_i[16*1 +: 16] = 16'hABCD;
        req_valid_i            = 4'b0010;
        cyc();
        rst         = 1'b1;
        req_valid_i = 4'b0110;
        #1;
        if ({buf_valid_o, buf_direct_o} !== 2'b00 || req_ready_o !== 4'h0) begin
            $display("FAIL rat_t1: got %b/%b want 00/0000", {buf_valid_o, buf_direct_o}, req_ready_o); n_err++;
        end
        n_vec++;
        cyc();
        rst = 1'b0;
        #1;
        if ({buf_valid_o, buf_direct_o} !== 2'b00 || wr_cnt_o !== 16'd0) begin
            $display("FAIL rat_t2: got %b/%0d want 00/0", {buf_valid_o, buf_direct_o}, wr_cnt_o); n_err++;
        end
        n_vec++;
        if (req_ready_o !== 4'b0010) begin
            $display("FAIL rat_ready: got %b want 0010", req_ready_o); n_err++;
        end
        n_vec++;
        cyc();
        req_valid_i = 4'h0;
        if (buf_valid_o !== 1'b1 || grant_o !== 3'd1 || wr_cnt_o !== 16'd1) begin
            $display("FAIL rat_grant: got %b/%0d/%0d want 1/1/1", buf_valid_o, grant_o, wr_cnt_o); n_err++;
        end
        n_vec++;
        cyc();
    endtask

    initial begin
        rst          = 1'b1;
        req_data_i   = '0;
        req_delay_i  = '0;
        req_valid_i  = '0;
        req_direct_i = '0;
        buf_full_i   = 1'b0;
        buf_err_i    = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_direct_priority();
        test_back_to_back();
        test_err();
        test_wrap();
        test_reset_after_transfer();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
